// File: rtl/out_vc_credit_ctrl_pkg.sv
// out_vc_credit_ctrl_pkg: shared defaults, VC state encoding and counter width helper
package out_vc_credit_ctrl_pkg;
  localparam int NUM_VC_DEF = 4;
  localparam int VC_INDEX_WIDTH_DEF = 2;
  localparam int BUF_DEPTH_DEF = 4;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } vc_state_e;
  function automatic int credit_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/out_vc_credit_ctrl_slot.sv
// vc_credit_slot: one downstream VC's credit counter and IDLE/ACTIVE/DRAIN state machine
module vc_credit_slot
  import out_vc_credit_ctrl_pkg::*;
#(
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int CNT_W = credit_cnt_w(BUF_DEPTH),
  parameter int ATOMIC_VC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send,
  input  logic             ret,
  input  logic             head,
  input  logic             tail,
  output logic [CNT_W-1:0] credit,
  output logic             busy,
  output logic             avail,
  output logic             err_under,
  output logic             err_over,
  output logic             err_proto
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  vc_state_e state, state_nxt;
  logic [CNT_W-1:0] credit_nxt;
  // a simultaneous send and return cancel out, so saturation only applies to lone events
  always_comb begin
    credit_nxt = credit;
    if (send && !ret) credit_nxt = (credit == '0) ? credit : credit - ONE;
    else if (ret && !send) credit_nxt = (credit == FULL) ? credit : credit + ONE;
  end
  assign err_under = send && !ret && credit == '0;
  assign err_over = ret && !send && credit == FULL;
  always_comb begin
    state_nxt = state;
    err_proto = 1'b0;
    case (state)
      IDLE: if (send) begin
        if (!head) err_proto = 1'b1;
        else if (!tail) state_nxt = ACTIVE;
        else if (ATOMIC_VC != 0) state_nxt = DRAIN;
      end
      ACTIVE: if (send) begin
        if (head) err_proto = 1'b1;
        else if (tail) state_nxt = (ATOMIC_VC != 0) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (send) err_proto = 1'b1;
        else if (credit_nxt == FULL) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit <= FULL;
      state <= IDLE;
    end else begin
      credit <= credit_nxt;
      state <= state_nxt;
    end
  end
  assign busy = state != IDLE;
  assign avail = state == IDLE && credit != '0;
endmodule

// File: rtl/out_vc_credit_ctrl.sv
// out_vc_credit_ctrl: per-output-port downstream VC credit tracker and free-VC selector
module out_vc_credit_ctrl
  import out_vc_credit_ctrl_pkg::*;
#(
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int CNT_W = credit_cnt_w(BUF_DEPTH),
  parameter int ATOMIC_VC = 1,
  parameter int VC_INDEX_WIDTH = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      send_valid,
  input  logic [VC_INDEX_WIDTH-1:0] send_vc,
  input  logic                      send_head,
  input  logic                      send_tail,
  input  logic                      credit_valid,
  input  logic [VC_INDEX_WIDTH-1:0] credit_vc,
  output logic [NUM_VC*CNT_W-1:0]   credit_out,
  output logic [NUM_VC-1:0]         vc_busy,
  output logic [NUM_VC-1:0]         vc_avail,
  output logic [VC_INDEX_WIDTH-1:0] vc_new,
  output logic                      vc_new_valid,
  output logic                      err_underflow,
  output logic                      err_overflow,
  output logic                      err_proto
);
  logic [NUM_VC-1:0] under_p, over_p, proto_p;
  for (genvar i = 0; i < NUM_VC; i++) begin : g_slot
    vc_credit_slot #(.BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W), .ATOMIC_VC(ATOMIC_VC)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .send      (send_valid && send_vc == VC_INDEX_WIDTH'(i)),
      .ret       (credit_valid && credit_vc == VC_INDEX_WIDTH'(i)),
      .head      (send_head),
      .tail      (send_tail),
      .credit    (credit_out[i*CNT_W +: CNT_W]),
      .busy      (vc_busy[i]),
      .avail     (vc_avail[i]),
      .err_under (under_p[i]),
      .err_over  (over_p[i]),
      .err_proto (proto_p[i])
    );
  end
  // scan from the top so the lowest available index wins
  always_comb begin
    vc_new = '0;
    for (int i = NUM_VC - 1; i >= 0; i--)
      if (vc_avail[i]) vc_new = VC_INDEX_WIDTH'(i);
  end
  assign vc_new_valid = |vc_avail;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_underflow <= 1'b0;
      err_overflow <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      err_underflow <= err_underflow | (|under_p);
      err_overflow <= err_overflow | (|over_p);
      err_proto <= err_proto | (|proto_p);
    end
  end
endmodule

// File: doc/out_vc_credit_ctrl.md
Name: out_vc_credit_ctrl

Overview:
- Per-output-port tracker of downstream VC state and buffer credits for the virtual-channel router.
- Supplies the per-VC credit counts and the new-VC choice that the switch allocator consumes for each output port.
- Counters are updated from flits granted through the crossbar and from credits returned by the downstream router.
- One instance per output port, so five per router.

Parameters:
NUM_VC, 4, number of virtual channels per port
BUF_DEPTH, 4, downstream input-buffer depth per VC in flits; also the reset credit value
CNT_W, $clog2(BUF_DEPTH+1), width of each credit counter
ATOMIC_VC, 1, 1 = a VC is not reallocated until all of its credits have returned after the tail flit

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
send_valid  in  1  a flit leaves on this output port this cycle
send_vc  in  VC_INDEX_WIDTH  downstream VC of the sent flit
send_head  in  1  sent flit is a head flit
send_tail  in  1  sent flit is a tail flit; head and tail together mean a single-flit packet
credit_valid  in  1  credit returned by the downstream router this cycle
credit_vc  in  VC_INDEX_WIDTH  VC the returned credit belongs to
credit_out  out  NUM_VC*CNT_W  flattened credit counters; VC i is at bits [i*CNT_W +: CNT_W]
vc_busy  out  NUM_VC  VC i is not IDLE
vc_avail  out  NUM_VC  VC i is IDLE and its credit is greater than 0
vc_new  out  VC_INDEX_WIDTH  lowest-index VC with vc_avail set; 0 when none is available
vc_new_valid  out  1  vc_avail is non-zero
err_underflow  out  1  sticky: a flit was sent on a VC with 0 credits
err_overflow  out  1  sticky: a credit was returned to a VC already at BUF_DEPTH
err_proto  out  1  sticky: a head or body/tail flit arrived in the wrong VC state

Behaviour:
- Reset values, applied asynchronously and held while reset is high:
  - every counter = BUF_DEPTH
  - every VC in IDLE
  - vc_busy = 0, vc_avail = all ones, vc_new = 0, vc_new_valid = 1
  - all error flags = 0
- Counters and states are registered. An event sampled at edge N is visible on the outputs after edge N.
- vc_avail, vc_new and vc_new_valid are combinational decodes of the registered state only. There is no path from the inputs to the outputs.
- Credit arithmetic, per VC:
  - A send to VC i decrements credit i.
  - A credit return to VC i increments credit i.
  - A send and a return to the same VC in the same cycle leave the count unchanged and raise no error, including at 0 and at BUF_DEPTH.
  - A send and a return to different VCs in the same cycle are independent.
  - Send at 0 credits: the count stays 0 (no wrap) and err_underflow is set.
  - Return at BUF_DEPTH credits: the count stays BUF_DEPTH and err_overflow is set.
- VC state machine, per VC, with states IDLE, ACTIVE, DRAIN:
  - IDLE, head without tail -> ACTIVE.
  - IDLE, head with tail -> DRAIN when ATOMIC_VC=1, otherwise stays IDLE.
  - ACTIVE, tail -> DRAIN when ATOMIC_VC=1, otherwise IDLE.
  - ACTIVE, body flit -> stays ACTIVE.
  - DRAIN -> IDLE in the cycle its next-state credit equals BUF_DEPTH, counting a return in that same cycle.
  - DRAIN is never entered when ATOMIC_VC=0.
- Protocol errors, which set err_proto and leave the state unchanged (the credit update still occurs):
  - head flit on an ACTIVE or DRAIN VC
  - non-head flit on an IDLE or DRAIN VC
- Error flags are cleared only by reset.
- Reset asserted mid-packet aborts everything. All VCs return to IDLE with full credit; in-flight returns are not tracked.

Decomposition:
- Shared package:
  - NUM_VC, VC_INDEX_WIDTH, BUF_DEPTH defaults
  - VC state encoding: IDLE=2'd0, ACTIVE=2'd1, DRAIN=2'd2
  - credit counter width function
- Sub-module vc_credit_slot, instantiated NUM_VC times:
  - holds one counter and one state machine
  - inputs: its decoded send/return strobes, head, tail
  - outputs: credit, busy, avail, and per-slot error pulses
- The top level contains the VC decoders, the lowest-index priority encoder and the sticky error registers.

Test Plan:
- Reset, then idle: credit_out = 4,4,4,4; vc_avail = 4'b1111; vc_new = 0; vc_new_valid = 1; all error flags 0.
- Head to VC0, two body flits, tail, each on consecutive cycles:
  - After the head: VC0 is ACTIVE, vc_new = 1.
  - After the tail: credit0 = 0 and VC0 is in DRAIN.
  - Return 4 credits: VC0 returns to IDLE in the cycle credit0 reaches 4, and vc_new goes back to 0.
- Simultaneous send and return on VC2 at credit 0 and again at credit 4: the count is unchanged and no error flag is set.
- Send on VC3 at credit 0: credit3 stays 0 and err_underflow = 1, sticky until reset. Return on VC1 at credit 4: err_overflow = 1.
- Head with tail (single-flit packet) on VC1:
  - ATOMIC_VC=1: DRAIN until its credit returns.
  - ATOMIC_VC=0: VC1 stays IDLE and vc_avail[1] = 1 while credit1 = 3.
- Head on an ACTIVE VC0 sets err_proto; body flit on an IDLE VC2 sets err_proto. Asserting reset mid-packet restores all counters to 4 and all VCs to IDLE asynchronously.
